// File: rtl/uart_cmd_rx.sv
// uart_cmd_rx: debug-UART write-command parser.
// Decodes "W<r>:<hex><EOL>" into a one-cycle register-write strobe.
module uart_cmd_rx #(
  parameter int DP_WIDTH = 16,
  parameter int NUM_NIB  = DP_WIDTH / 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          i_rx_data,
  input  logic                i_rx_valid,
  output logic [1:0]          o_wr_reg,
  output logic [DP_WIDTH-1:0] o_wr_data,
  output logic                o_wr_stb,
  output logic                o_err,
  output logic                o_busy
);

  localparam int CW = $clog2(NUM_NIB + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REG,
    ST_COLON,
    ST_HEX
  } state_e;

  state_e              state_q;
  logic [DP_WIDTH-1:0] acc_q;
  logic [CW-1:0]       cnt_q;
  logic [1:0]          idx_q;
  logic [1:0]          wr_reg_q;
  logic [DP_WIDTH-1:0] wr_data_q;
  logic                stb_q;
  logic                err_q;

  logic       is_w;
  logic       is_idx;
  logic       is_colon;
  logic       is_eol;
  logic       is_hex;
  logic [3:0] nib;

  // Classify the incoming byte and convert hex digits to a nibble.
  always_comb begin
    is_w     = (i_rx_data == 8'h57) || (i_rx_data == 8'h77);
    is_idx   = (i_rx_data >= 8'h30) && (i_rx_data <= 8'h33);
    is_colon = (i_rx_data == 8'h3A);
    is_eol   = (i_rx_data == 8'h0D) || (i_rx_data == 8'h0A);
    is_hex   = 1'b0;
    nib      = 4'h0;
    if ((i_rx_data >= 8'h30) && (i_rx_data <= 8'h39)) begin
      is_hex = 1'b1;
      nib    = i_rx_data[3:0];
    end else if (((i_rx_data >= 8'h41) && (i_rx_data <= 8'h46)) ||
                 ((i_rx_data >= 8'h61) && (i_rx_data <= 8'h66))) begin
      is_hex = 1'b1;
      nib    = i_rx_data[3:0] + 4'd9;
    end
  end

  // Parser FSM; strobe and error are one-cycle registered pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      idx_q     <= 2'd0;
      wr_reg_q  <= 2'd0;
      wr_data_q <= '0;
      stb_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      stb_q <= 1'b0;
      err_q <= 1'b0;
      if (i_rx_valid) begin
        if ((state_q != ST_IDLE) && is_w) begin
          err_q   <= 1'b1;
          state_q <= ST_REG;
          acc_q   <= '0;
          cnt_q   <= '0;
        end else begin
          unique case (state_q)
            ST_IDLE: begin
              if (is_w) begin
                state_q <= ST_REG;
                acc_q   <= '0;
                cnt_q   <= '0;
              end
            end
            ST_REG: begin
              if (is_idx) begin
                idx_q   <= i_rx_data[1:0];
                state_q <= ST_COLON;
              end else begin
                err_q   <= 1'b1;
                state_q <= ST_IDLE;
              end
            end
            ST_COLON: begin
              if (is_colon) begin
                state_q <= ST_HEX;
              end else begin
                err_q   <= 1'b1;
                state_q <= ST_IDLE;
              end
            end
            ST_HEX: begin
              if (is_hex && (cnt_q != CW'(NUM_NIB))) begin
                acc_q <= {acc_q[DP_WIDTH-5:0], nib};
                cnt_q <= cnt_q + 1'b1;
              end else if (is_eol && (cnt_q != '0)) begin
                stb_q     <= 1'b1;
                wr_reg_q  <= idx_q;
                wr_data_q <= acc_q;
                state_q   <= ST_IDLE;
              end else begin
                err_q   <= 1'b1;
                state_q <= ST_IDLE;
              end
            end
            default: state_q <= ST_IDLE;
          endcase
        end
      end
    end
  end

  assign o_wr_reg  = wr_reg_q;
  assign o_wr_data = wr_data_q;
  assign o_wr_stb  = stb_q;
  assign o_err     = err_q;
  assign o_busy    = (state_q != ST_IDLE);

endmodule
